// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-level stream demultiplexer, one input routed to one of N outputs
module stream_demux #(
    parameter int N     = 3,
    parameter int W     = 8,
    parameter int CNT_W = 16,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [W-1:0]     s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic [SEL_W-1:0] s_tdest,
    output logic [W-1:0]     m_tdata,
    output logic             m_tlast,
    output logic [N-1:0]     m_tvalid,
    input  logic [N-1:0]     m_tready,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   pkt_dest;
    logic [SEL_W-1:0]   out_dest;
    logic [SEL_W-1:0]   cur_dest;
    logic               out_valid;
    logic               drain;
    logic               accept;
    logic               dest_ok;
    logic               route_beat;
    logic               drop_done;

    assign dest_ok = (32'(s_tdest) < N);
    assign accept  = s_tvalid & s_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            pkt_dest <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && !s_tlast && dest_ok) begin
                pkt_dest <= s_tdest;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !s_tlast) begin
                    state_nxt = dest_ok ? ROUTE : DROP;
                end
            end
            ROUTE, DROP: begin
                if (accept && s_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the ready bit of the channel currently holding the register matters.
    always_comb begin
        drain = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (out_dest == SEL_W'(i)) begin
                drain = m_tready[i];
            end
        end
        drain = drain & out_valid;
    end

    always_comb begin
        s_tready   = 1'b0;
        route_beat = 1'b0;
        drop_done  = 1'b0;
        cur_dest   = pkt_dest;
        case (state)
            IDLE: begin
                s_tready   = ~out_valid | drain;
                cur_dest   = s_tdest;
                route_beat = accept & dest_ok;
                drop_done  = accept & s_tlast & ~dest_ok;
            end
            ROUTE: begin
                s_tready   = ~out_valid | drain;
                route_beat = accept;
            end
            DROP: begin
                s_tready  = 1'b1;
                drop_done = accept & s_tlast;
            end
            default: begin
                s_tready = 1'b0;
            end
        endcase
    end

    // Destination, data and last load together so a channel switch is atomic.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_valid  <= 1'b0;
            out_dest   <= '0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            drop_count <= '0;
        end else begin
            if (route_beat) begin
                out_valid <= 1'b1;
                out_dest  <= cur_dest;
                m_tdata   <= s_tdata;
                m_tlast   <= s_tlast;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drop_done && drop_count != {CNT_W{1'b1}}) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        m_tvalid = '0;
        for (int i = 0; i < N; i++) begin
            m_tvalid[i] = out_valid & (out_dest == SEL_W'(i));
        end
    end

    assign busy = (state != IDLE) | out_valid;

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed vector bench for stream_demux
module tb_stream_demux;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [1:0]  s_tdest;
    logic [2:0]  m_tready;

    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic [2:0]  m_tvalid;
    logic [15:0] drop_count;
    logic        busy;

    logic        s_tready2;
    logic [7:0]  m_tdata2;
    logic        m_tlast2;
    logic [2:0]  m_tvalid2;
    logic [1:0]  drop_count2;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    always #5 aclk = ~aclk;

    stream_demux #(.N(3), .W(8), .CNT_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tdest(s_tdest),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .drop_count(drop_count), .busy(busy)
    );

    stream_demux #(.N(3), .W(8), .CNT_W(2)) dut_sat (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready2),
        .s_tlast(s_tlast), .s_tdest(s_tdest),
        .m_tdata(m_tdata2), .m_tlast(m_tlast2), .m_tvalid(m_tvalid2),
        .m_tready(m_tready), .drop_count(drop_count2), .busy(busy2)
    );

    typedef struct {
        logic        rstn;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [1:0]  dest;
        logic [2:0]  rdy;
        logic        e_srdy;
        logic [2:0]  e_mv;
        logic [7:0]  e_d;
        logic        e_l;
        logic [15:0] e_drop;
        logic        e_busy;
        logic        cd;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rstn, input logic v, input logic [7:0] d, input logic l,
                       input logic [1:0] dest, input logic [2:0] rdy, input logic e_srdy,
                       input logic [2:0] e_mv, input logic [7:0] e_d, input logic e_l,
                       input logic [15:0] e_drop, input logic e_busy, input logic cd);
        vec_t x;
        x.rstn = rstn; x.v = v; x.d = d; x.l = l; x.dest = dest; x.rdy = rdy;
        x.e_srdy = e_srdy; x.e_mv = e_mv; x.e_d = e_d; x.e_l = e_l;
        x.e_drop = e_drop; x.e_busy = e_busy; x.cd = cd;
        vt.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual %0h required %0h", name, row, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        s_tlast  = 1'b0;
        s_tdest  = 2'd0;
        m_tready = 3'b111;
        @(posedge aclk); #1;

        //   rst v  data   l  dst  rdy     srdy mv      data   l  drop busy cd
        add(0, 0, 8'h00, 0, 2'd0, 3'b111, 1, 3'b000, 8'h00, 0, 0, 0, 1);
        // 3-beat packet to channel 1
        add(1, 1, 8'h11, 0, 2'd1, 3'b111, 1, 3'b010, 8'h11, 0, 0, 1, 1);
        add(1, 1, 8'h22, 0, 2'd1, 3'b111, 1, 3'b010, 8'h22, 0, 0, 1, 1);
        add(1, 1, 8'h33, 1, 2'd1, 3'b111, 1, 3'b010, 8'h33, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 2'd0, 3'b111, 1, 3'b000, 8'h00, 0, 0, 0, 0);
        // backpressure on channel 0 for five cycles
        add(1, 1, 8'hA0, 0, 2'd0, 3'b111, 1, 3'b001, 8'hA0, 0, 0, 1, 1);
        for (int k = 0; k < 5; k++)
            add(1, 1, 8'hA1, 0, 2'd0, 3'b110, 0, 3'b001, 8'hA0, 0, 0, 1, 1);
        add(1, 1, 8'hA1, 0, 2'd0, 3'b111, 1, 3'b001, 8'hA1, 0, 0, 1, 1);
        add(1, 1, 8'hA2, 0, 2'd0, 3'b111, 1, 3'b001, 8'hA2, 0, 0, 1, 1);
        add(1, 1, 8'hA3, 1, 2'd0, 3'b111, 1, 3'b001, 8'hA3, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 2'd0, 3'b111, 1, 3'b000, 8'h00, 0, 0, 0, 0);
        // drops: 2-beat then 1-beat to dest 3; DROP ignores m_tready
        add(1, 1, 8'h55, 0, 2'd3, 3'b111, 1, 3'b000, 8'h00, 0, 0, 1, 0);
        add(1, 1, 8'h66, 1, 2'd3, 3'b000, 1, 3'b000, 8'h00, 0, 1, 0, 0);
        add(1, 1, 8'h77, 1, 2'd3, 3'b111, 1, 3'b000, 8'h00, 0, 2, 0, 0);
        add(1, 0, 8'h00, 0, 2'd0, 3'b111, 1, 3'b000, 8'h00, 0, 2, 0, 0);
        // back-to-back single beats to different channels
        add(1, 1, 8'h5A, 1, 2'd2, 3'b111, 1, 3'b100, 8'h5A, 1, 2, 1, 1);
        add(1, 1, 8'hC3, 1, 2'd0, 3'b111, 1, 3'b001, 8'hC3, 1, 2, 1, 1);
        add(1, 0, 8'h00, 0, 2'd0, 3'b111, 1, 3'b000, 8'h00, 0, 2, 0, 0);
        // s_tdest changes mid-packet are ignored
        add(1, 1, 8'h10, 0, 2'd1, 3'b111, 1, 3'b010, 8'h10, 0, 2, 1, 1);
        add(1, 1, 8'h20, 0, 2'd2, 3'b111, 1, 3'b010, 8'h20, 0, 2, 1, 1);
        add(1, 1, 8'h30, 1, 2'd2, 3'b111, 1, 3'b010, 8'h30, 1, 2, 1, 1);
        add(1, 0, 8'h00, 0, 2'd0, 3'b111, 1, 3'b000, 8'h00, 0, 2, 0, 0);
        // reset mid-packet, then a fresh first beat to channel 2
        add(1, 1, 8'h40, 0, 2'd1, 3'b111, 1, 3'b010, 8'h40, 0, 2, 1, 1);
        add(0, 1, 8'h41, 0, 2'd1, 3'b111, 1, 3'b000, 8'h00, 0, 0, 0, 1);
        add(1, 1, 8'h42, 1, 2'd2, 3'b111, 1, 3'b100, 8'h42, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 2'd0, 3'b111, 1, 3'b000, 8'h00, 0, 0, 0, 0);

        foreach (vt[i]) begin
            row      = i;
            aresetn  = vt[i].rstn;
            s_tvalid = vt[i].v;
            s_tdata  = vt[i].d;
            s_tlast  = vt[i].l;
            s_tdest  = vt[i].dest;
            m_tready = vt[i].rdy;
            #1;
            chk("s_tready", 32'(s_tready), 32'(vt[i].e_srdy));
            @(posedge aclk); #1;
            chk("m_tvalid", 32'(m_tvalid), 32'(vt[i].e_mv));
            chk("drop_count", 32'(drop_count), 32'(vt[i].e_drop));
            chk("busy", 32'(busy), 32'(vt[i].e_busy));
            if (vt[i].cd) begin
                chk("m_tdata", 32'(m_tdata), 32'(vt[i].e_d));
                chk("m_tlast", 32'(m_tlast), 32'(vt[i].e_l));
            end
        end

        // counter saturation on the CNT_W=2 instance
        row      = 100;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
        chk("sat_reset", 32'(drop_count2), 32'd0);
        aresetn  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] exp_sat;
            exp_sat  = (k < 3) ? 2'(k + 1) : 2'd3;
            row      = 101 + k;
            s_tvalid = 1'b1;
            s_tlast  = 1'b1;
            s_tdest  = 2'd3;
            s_tdata  = 8'(8'hE0 + k);
            @(posedge aclk); #1;
            chk("drop_sat", 32'(drop_count2), 32'(exp_sat));
            chk("drop_wide", 32'(drop_count), 32'(k + 1));
            chk("sat_no_valid", 32'(m_tvalid2), 32'd0);
        end
        s_tvalid = 1'b0;
        @(posedge aclk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Packet-level stream demultiplexer; the inverse of the team's mux. One AXI-Stream-style input is routed to one of N outputs.
- The destination is sampled on the first beat of each packet and held until the tlast beat is accepted.
- Output is one registered stage. Packets with an out-of-range destination are dropped and counted.
- Sits between a shared ingress stream and per-channel consumers.

Parameters:
- N, 3, number of output channels (N >= 2)
- W, 8, data width in bits
- CNT_W, 16, width of drop counter
- SEL_W, derived localparam = $clog2(N), destination field width

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low; single clock domain
- s_tdata  in  W  input data
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat accepted when s_tvalid & s_tready
- s_tlast  in  1  last beat of packet
- s_tdest  in  SEL_W  destination; sampled on first beat only
- m_tdata  out  W  output data, shared by all channels
- m_tlast  out  1  output last, shared
- m_tvalid  out  N  one-hot per-channel valid
- m_tready  in  N  per-channel ready
- drop_count  out  CNT_W  saturating count of dropped packets
- busy  out  1  high while a packet is open (state != IDLE) or the output register is full

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - state=IDLE, out_valid=0, m_tvalid=0, m_tdata=0, m_tlast=0, drop_count=0, busy=0.
  - Any beat in flight is discarded.
  - Reset mid-packet abandons the packet; the next accepted beat is treated as a first beat.
- State machine:
  - IDLE -> ROUTE: accepted beat with s_tlast=0 and s_tdest<N. Latch pkt_dest=s_tdest.
  - IDLE -> DROP: accepted beat with s_tlast=0 and s_tdest>=N.
  - IDLE stays IDLE: accepted beat with s_tlast=1 (single-beat packet). The beat is routed, or dropped if s_tdest>=N.
  - ROUTE -> IDLE: accepted beat with s_tlast=1. s_tdest is ignored in ROUTE.
  - DROP -> IDLE: accepted beat with s_tlast=1. s_tdest is ignored in DROP.
- Output register:
  - Holds out_valid, out_dest, data and last.
  - m_tvalid[i] = out_valid & (out_dest==i).
  - drain = out_valid & m_tready[out_dest].
- s_tready:
  - IDLE, ROUTE: s_tready = ~out_valid | drain. This is combinational from m_tready, so there are no bubbles at full rate.
  - DROP: s_tready = 1 always. Beats are consumed with no output.
  - An IDLE first beat with s_tdest>=N also obeys the IDLE rule, then is discarded.
- Load:
  - When an accepted beat is routed (a valid destination, not a drop), it loads the register the next edge.
  - Latency is 1 cycle from input acceptance to m_tvalid.
  - Drain and load in the same cycle: register takes the new beat, out_valid stays 1.
  - Drain without load: out_valid=0.
- Back-to-back packets to different channels:
  - Allowed with no idle cycle.
  - The new first beat loads only when the previous beat drains that cycle. out_dest changes atomically with the data.
- m_tvalid is never withdrawn, and m_tdata/m_tlast never change, while m_tvalid[i]=1 and m_tready[i]=0 (AXI stability).
- drop_count:
  - Increments by 1 when a dropped packet's tlast beat is accepted, or when a single-beat packet is dropped.
  - Saturates at 2^CNT_W-1; no wrap.
- m_tready bits for channels other than out_dest have no effect.

Test Plan:
- Routing and latency:
  - Stimulus: after reset release, send a 3-beat packet dest=1, data 0x11,0x22,0x33, all m_tready=1.
  - Response: m_tvalid=3'b010 for 3 consecutive cycles starting 1 cycle after the first accept; m_tlast with 0x33 only; s_tready constant 1.
- Backpressure:
  - Stimulus: 4-beat packet dest=0, data 0xA0..0xA3; m_tready[0] low for 5 cycles after the first beat loads.
  - Response: m_tdata holds 0xA0 with m_tvalid[0]=1 throughout; s_tready=0 while stalled; all 4 beats delivered in order, none lost.
- Drops:
  - Stimulus: 2-beat packet dest=3 (invalid for N=3), then a 1-beat packet dest=3.
  - Response: no m_tvalid bit asserts; s_tready=1 during the DROP beats; drop_count ends at 2.
- Back-to-back different destinations:
  - Stimulus: single-beat packet dest=2 data 0x5A, immediately followed by single-beat dest=0 data 0xC3; m_tready=3'b111.
  - Response: m_tvalid=3'b100 with 0x5A, next cycle m_tvalid=3'b001 with 0xC3; no idle cycle.
- Mid-packet dest change and reset:
  - Stimulus: packet dest=1, with s_tdest driven to 2 on beats 2-3.
  - Response: all beats go to channel 1.
  - Stimulus: aresetn=0 for 1 cycle mid-packet.
  - Response: m_tvalid=0, busy=0, drop_count=0 next cycle; the following beat with dest=2 routes to channel 2.
- Counter saturation:
  - Stimulus: CNT_W=2, drop 5 single-beat packets with dest=3.
  - Response: drop_count reads 1,2,3,3,3.
